nibble_add_seq: RTL and testbench

Sequential controller that performs a wide add of two 4·NIBBLES-bit operands through a single external 4-bit ripple-carry adder, one nibble per clock, least-significant nibble first. It sits directly upstream of the 4-bit adder, driving its a/b/carry-in bits. It also sits downstream of it, capturing each nibble sum and carry-out. It holds the inter-nibble carry in a register and presents the assembled result with a done pulse.

---
 rtl/nibble_add_seq_if.sv | 50 +++++
 rtl/nibble_add_seq.sv | 120 ++++++++++++
 tb/tb_nibble_add_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_if.sv
// Bus bundle for nibble_add_seq: host request/response plus the 4-bit external adder link.
// The ovf signal exists only when NIBBLE_ADD_OVF_EN is defined.
interface nibble_add_seq_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
`ifdef NIBBLE_ADD_OVF_EN
   logic         ovf;
`endif
   logic         add_a0, add_a1, add_a2, add_a3;
   logic         add_b0, add_b1, add_b2, add_b3;
   logic         add_cin;
   logic         add_s0, add_s1, add_s2, add_s3;
   logic         add_cout;

   // master is the environment: host plus the combinational adder returning sums
`ifdef NIBBLE_ADD_OVF_EN
   modport master (
      output start, op_a, op_b, cin, add_s0, add_s1, add_s2, add_s3, add_cout,
      input  busy, done, result, cout, ovf,
      input  add_a0, add_a1, add_a2, add_a3, add_b0, add_b1, add_b2, add_b3, add_cin
   );
   modport slave (
      input  start, op_a, op_b, cin, add_s0, add_s1, add_s2, add_s3, add_cout,
      output busy, done, result, cout, ovf,
      output add_a0, add_a1, add_a2, add_a3, add_b0, add_b1, add_b2, add_b3, add_cin
   );
`else
   modport master (
      output start, op_a, op_b, cin, add_s0, add_s1, add_s2, add_s3, add_cout,
      input  busy, done, result, cout,
      input  add_a0, add_a1, add_a2, add_a3, add_b0, add_b1, add_b2, add_b3, add_cin
   );
   modport slave (
      input  start, op_a, op_b, cin, add_s0, add_s1, add_s2, add_s3, add_cout,
      output busy, done, result, cout,
      output add_a0, add_a1, add_a2, add_a3, add_b0, add_b1, add_b2, add_b3, add_cin
   );
`endif

endinterface

// File: rtl/nibble_add_seq.sv
// Wide adder that time-multiplexes one external 4-bit ripple adder, LS nibble first.
// Define NIBBLE_ADD_OVF_EN to add a registered signed-overflow flag (ovf).
module nibble_add_seq #(
   parameter int NIBBLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   nibble_add_seq_if.slave  bus
);

   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [W-1:0]    r_opA;
   logic [W-1:0]    r_opB;
   logic [W-1:0]    r_result;
   logic [IDXW-1:0] r_idx;
   logic            r_carry;
   logic            r_cout;
`ifdef NIBBLE_ADD_OVF_EN
   logic            r_ovf;
`endif

   logic            w_busy;
   logic            w_accept;
   logic            w_lastNibble;
   logic [W-1:0]    w_shA;
   logic [W-1:0]    w_shB;
   logic [3:0]      w_nibA;
   logic [3:0]      w_nibB;
   logic [3:0]      w_sum;

   assign w_busy       = (r_state == ADD);
   assign w_accept     = bus.start && (r_state != ADD);
   assign w_lastNibble = (r_idx == IDXW'(NIBBLES - 1));

   assign w_shA  = r_opA >> {r_idx, 2'b00};
   assign w_shB  = r_opB >> {r_idx, 2'b00};
   assign w_nibA = w_busy ? w_shA[3:0] : 4'h0;
   assign w_nibB = w_busy ? w_shB[3:0] : 4'h0;
   assign w_sum  = {bus.add_s3, bus.add_s2, bus.add_s1, bus.add_s0};

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_nextState = ADD;
         ADD:     if (w_lastNibble) w_nextState = DONE;
         DONE:    w_nextState = bus.start ? ADD : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Accept clears the previous answer; otherwise each ADD edge captures one nibble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_opA    <= '0;
         r_opB    <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_opA    <= bus.op_a;
            r_opB    <= bus.op_b;
            r_carry  <= bus.cin;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
            r_ovf    <= 1'b0;
`endif
         end else if (w_busy) begin
            for (int n = 0; n < NIBBLES; n++) begin
               if (r_idx == IDXW'(n)) r_result[4*n +: 4] <= w_sum;
            end
            r_carry <= bus.add_cout;
            if (w_lastNibble) begin
               r_cout <= bus.add_cout;
`ifdef NIBBLE_ADD_OVF_EN
               r_ovf  <= (w_nibA[3] == w_nibB[3]) && (bus.add_s3 != w_nibA[3]);
`endif
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   assign bus.busy    = w_busy;
   assign bus.done    = (r_state == DONE);
   assign bus.result  = r_result;
   assign bus.cout    = r_cout;
`ifdef NIBBLE_ADD_OVF_EN
   assign bus.ovf     = r_ovf;
`endif
   assign bus.add_a0  = w_nibA[0];
   assign bus.add_a1  = w_nibA[1];
   assign bus.add_a2  = w_nibA[2];
   assign bus.add_a3  = w_nibA[3];
   assign bus.add_b0  = w_nibB[0];
   assign bus.add_b1  = w_nibB[1];
   assign bus.add_b2  = w_nibB[2];
   assign bus.add_b3  = w_nibB[3];
   assign bus.add_cin = w_busy & r_carry;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (NIBBLES=4) with a behavioural 4-bit adder.
// Honours NIBBLE_ADD_OVF_EN to also check the ovf flag.
module tb_nibble_add_seq;

   localparam int NIBBLES = 4;

   logic clk;
   logic rst;
   int   checkCount;
   int   errorCount;

   nibble_add_seq_if #(.NIBBLES(NIBBLES)) bus ();

   nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // External adder: purely combinational, plain arithmetic on the driven nibbles
   logic [4:0] adderSum;
   assign adderSum = {1'b0, bus.add_a3, bus.add_a2, bus.add_a1, bus.add_a0}
                   + {1'b0, bus.add_b3, bus.add_b2, bus.add_b1, bus.add_b0}
                   + {4'b0, bus.add_cin};
   assign {bus.add_cout, bus.add_s3, bus.add_s2, bus.add_s1, bus.add_s0} = adderSum;

   logic [8:0] addDrive;
   assign addDrive = {bus.add_a3, bus.add_a2, bus.add_a1, bus.add_a0,
                      bus.add_b3, bus.add_b2, bus.add_b1, bus.add_b0, bus.add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Expected adder drive at nibble k: operand nibbles and the carry out of the lower k nibbles
   function automatic logic [8:0] expectedDrive(input logic [15:0] a, input logic [15:0] b,
                                                input logic c, input int k);
      int unsigned av, bv, mask, aN, bN, cIn;
      av   = a;
      bv   = b;
      mask = (32'd1 << (4 * k)) - 1;
      aN   = (av >> (4 * k)) & 15;
      bN   = (bv >> (4 * k)) & 15;
      cIn  = (((av & mask) + (bv & mask) + c) >> (4 * k)) & 1;
      return {aN[3:0], bN[3:0], cIn[0]};
   endfunction

   task automatic checkFinal(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c);
      logic [16:0] total;
      total = 17'(a) + 17'(b) + 17'(c);
      checkOutput({tag, ".result"}, 32'(bus.result), 32'(total[15:0]));
      checkOutput({tag, ".cout"}, 32'(bus.cout), 32'(total[16]));
`ifdef NIBBLE_ADD_OVF_EN
      checkOutput({tag, ".ovf"}, 32'(bus.ovf),
                  32'((a[15] == b[15]) && (total[15] != a[15])));
`endif
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.cin   = c;
      for (int k = 0; k < NIBBLES; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd1);
         checkOutput({tag, ".doneEarly"}, 32'(bus.done), 32'd0);
         checkOutput({tag, ".drive"}, 32'(addDrive), 32'(expectedDrive(a, b, c, k)));
      end
      @(negedge clk);
      checkOutput({tag, ".done"}, 32'(bus.done), 32'd1);
      checkOutput({tag, ".busyDone"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, ".driveIdle"}, 32'(addDrive), 32'd0);
      checkFinal(tag, a, b, c);
      @(negedge clk);
      checkOutput({tag, ".donePulse"}, 32'(bus.done), 32'd0);
      checkFinal({tag, ".hold"}, a, b, c);
   endtask

   initial begin
      int doneCount;
      logic [15:0] resAtDone;
      logic [15:0] ra, rb;
      logic rc;

      checkCount = 0;
      errorCount = 0;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      bus.cin    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset.busy", 32'(bus.busy), 32'd0);
      checkOutput("reset.done", 32'(bus.done), 32'd0);
      checkOutput("reset.result", 32'(bus.result), 32'd0);
      checkOutput("reset.cout", 32'(bus.cout), 32'd0);
      checkOutput("reset.drive", 32'(addDrive), 32'd0);
`ifdef NIBBLE_ADD_OVF_EN
      checkOutput("reset.ovf", 32'(bus.ovf), 32'd0);
`endif
      rst = 1'b0;

      applyStimulus(16'h1234, 16'h0FFF, 1'b0, "basic");
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, "wrap");
      applyStimulus(16'h7FFF, 16'h0000, 1'b1, "ripple");

      // start pulsed mid-ADD must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = 16'h0001; bus.op_b = 16'h0001; bus.cin = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = 16'hAAAA; bus.op_b = 16'h5555;
      doneCount = 0;
      resAtDone = '0;
      for (int cyc = 3; cyc <= 8; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) begin
            doneCount++;
            resAtDone = bus.result;
         end
      end
      checkOutput("ignore.doneCount", 32'(doneCount), 32'd1);
      checkOutput("ignore.result", 32'(resAtDone), 32'h0002);

      // back-to-back with start held high through DONE
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = 16'h00FF; bus.op_b = 16'h0001; bus.cin = 1'b0;
      for (int cyc = 1; cyc <= 11; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            bus.op_a = 16'h1000;
            bus.op_b = 16'h1000;
         end
         if (cyc == 9) bus.start = 1'b0;
         if (cyc == 5) begin
            checkOutput("b2b.done5", 32'(bus.done), 32'd1);
            checkOutput("b2b.result5", 32'(bus.result), 32'h0100);
         end else if (cyc == 10) begin
            checkOutput("b2b.done10", 32'(bus.done), 32'd1);
            checkOutput("b2b.result10", 32'(bus.result), 32'h2000);
         end else begin
            checkOutput($sformatf("b2b.noDone%0d", cyc), 32'(bus.done), 32'd0);
         end
         if (cyc == 6) checkOutput("b2b.busy6", 32'(bus.busy), 32'd1);
      end

      // reset during ADD discards the partial sum and suppresses done
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.cin = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rstMid.busy", 32'(bus.busy), 32'd0);
      checkOutput("rstMid.result", 32'(bus.result), 32'd0);
      checkOutput("rstMid.cout", 32'(bus.cout), 32'd0);
      doneCount = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (bus.done) doneCount++;
         @(negedge clk);
      end
      checkOutput("rstMid.noDone", 32'(doneCount), 32'd0);
      applyStimulus(16'h4321, 16'h1234, 1'b0, "afterRst");

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         applyStimulus(ra, rb, rc, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
